frac_div_sched: RTL and testbench

FRAC_DIV_SCHED -- requirements
Module: frac_div_sched

---
 rtl/frac_div_sched.sv | 185 ++++++++++++++++++
 tb/tb_frac_div_sched.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/frac_div_sched.sv
// frac_div_sched: arbitrates two requesters onto one fixed-latency
// fractional divider and returns each quotient over a valid/ready response
// channel.
//
// Ports:
//   clk, rst_n             clock (posedge), asynchronous active-low reset
//   req{0,1}_valid/ready   operand handshake per requester (ready is combinational)
//   req{0,1}_a/_b          dividend / divisor, format 0.x, NI bits
//   div_start              one-cycle start pulse to the shared divider
//   div_a, div_b           operands to the divider, held until the result is taken
//   div_q                  divider quotient, format q[0].q[-1..-NO]
//   rsp_valid/ready        response handshake
//   rsp_id                 index of the requester being answered
//   rsp_q                  quotient (all ones on divide-by-zero)
//   rsp_err                divide-by-zero flag
//   busy                   high whenever the scheduler is not idle
module frac_div_sched #(
    parameter int unsigned NI  = 32,
    parameter int unsigned NO  = 40,
    parameter int unsigned LAT = 43
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [NI-1:0] req0_a,
    input  logic [NI-1:0] req0_b,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [NI-1:0] req1_a,
    input  logic [NI-1:0] req1_b,
    output logic          div_start,
    output logic [NI-1:0] div_a,
    output logic [NI-1:0] div_b,
    input  logic [NO:0]   div_q,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic          rsp_id,
    output logic [NO:0]   rsp_q,
    output logic          rsp_err,
    output logic          busy
);

    localparam int unsigned CW = (LAT < 2) ? 1 : $clog2(LAT + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    logic [1:0]    state;
    logic [1:0]    next_state;
    logic          prio;
    logic [CW-1:0] cnt;

    logic          grant_c;
    logic          accept_c;
    logic          b_zero_c;
    logic          wait_done_c;
    logic [NI-1:0] sel_a_c;
    logic [NI-1:0] sel_b_c;

    // Arbitration: a lone requester wins, otherwise the priority holder wins.
    always_comb begin
        grant_c    = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_c = prio;
        end else begin
            grant_c = req1_valid;
        end
        if (state == IDLE) begin
            req0_ready = req0_valid && !grant_c;
            req1_ready = req1_valid &&  grant_c;
        end
    end

    // Operands of the granted requester.
    always_comb begin
        sel_a_c     = grant_c ? req1_a : req0_a;
        sel_b_c     = grant_c ? req1_b : req0_b;
        accept_c    = req0_ready || req1_ready;
        b_zero_c    = (sel_b_c == '0);
        // cnt holds LAT on the first WAIT cycle, so cnt==1 is the LAT-th edge.
        wait_done_c = (cnt <= CW'(1));
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept_c) begin
                    next_state = b_zero_c ? RESP : START;
                end
            end
            START: begin
                next_state = WAIT;
            end
            WAIT: begin
                if (wait_done_c) begin
                    next_state = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Status outputs derived from the upcoming state so they align with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_start <= 1'b0;
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            div_start <= (state == IDLE) && (next_state == START);
            rsp_valid <= (next_state == RESP);
            busy      <= (next_state != IDLE);
        end
    end

    // Operand capture, latency counter, response data and priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_a   <= '0;
            div_b   <= '0;
            cnt     <= '0;
            rsp_id  <= 1'b0;
            rsp_q   <= '0;
            rsp_err <= 1'b0;
            prio    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept_c) begin
                        div_a  <= sel_a_c;
                        div_b  <= sel_b_c;
                        rsp_id <= grant_c;
                        if (b_zero_c) begin
                            rsp_q   <= '1;
                            rsp_err <= 1'b1;
                        end
                    end
                end
                START: begin
                    cnt <= CW'(LAT);
                end
                WAIT: begin
                    cnt <= cnt - CW'(1);
                    if (wait_done_c) begin
                        rsp_q   <= div_q;
                        rsp_err <= 1'b0;
                    end
                end
                RESP: begin
                    // Fairness: the requester not just served gets priority.
                    if (rsp_ready) begin
                        prio <= ~rsp_id;
                    end
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frac_div_sched.sv
module tb_frac_div_sched;

    localparam int unsigned NI  = 32;
    localparam int unsigned NO  = 40;
    localparam int unsigned LAT = 24;
    localparam int unsigned QW  = NO + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0_valid, req1_valid;
    logic          req0_ready, req1_ready;
    logic [NI-1:0] req0_a, req0_b, req1_a, req1_b;
    logic          div_start;
    logic [NI-1:0] div_a, div_b;
    logic [QW-1:0] div_q;
    logic          rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
    logic [QW-1:0] rsp_q;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic exp_prio;

    frac_div_sched #(.NI(NI), .NO(NO), .LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .div_start(div_start), .div_a(div_a), .div_b(div_b), .div_q(div_q),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_q(rsp_q), .rsp_err(rsp_err), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected quotient of 0.a / 0.b scaled by 2^NO, all ones for b==0.
    function automatic logic [QW-1:0] ref_q(input logic [NI-1:0] a, input logic [NI-1:0] b);
        logic [127:0] num;
        if (b == '0) return '1;
        num = 128'(a) << NO;
        return QW'(num / 128'(b));
    endfunction

    // Divider model: correct quotient only on the LAT-th edge after div_start
    // is sampled; neighbouring edges see distinct wrong values.
    bit            dm_active = 1'b0;
    int            dm_k = 0;
    logic [QW-1:0] dm_q = '0;
    always begin
        @(posedge clk);
        if (!rst_n) begin
            dm_active = 1'b0;
        end else if (div_start) begin
            dm_active = 1'b1;
            dm_k      = 0;
            dm_q      = ref_q(div_a, div_b);
        end else if (dm_active) begin
            dm_k++;
        end
        #1;
        if (dm_active)
            div_q = (dm_k == int'(LAT) - 1) ? dm_q : dm_q + QW'(dm_k + 1);
        else
            div_q = QW'({$urandom, $urandom});
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One request from a single requester; called at a negedge in IDLE.
    task automatic run_one(input bit id, input logic [NI-1:0] a, input logic [NI-1:0] b,
                           input int stall);
        int first, starts;
        bit stable, hold;
        logic [QW-1:0] eq;
        eq = ref_q(a, b);
        rsp_ready = (stall == 0);
        if (id == 1'b0) begin req0_valid = 1'b1; req0_a = a; req0_b = b; end
        else            begin req1_valid = 1'b1; req1_a = a; req1_b = b; end
        #1;
        chk("ready_granted", {63'd0, id ? req1_ready : req0_ready}, 64'd1);
        chk("ready_other",   {63'd0, id ? req0_ready : req1_ready}, 64'd0);
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = $urandom; req0_b = $urandom; req1_a = $urandom; req1_b = $urandom;
        first = 0; starts = 0; stable = 1'b1;
        for (int n = 1; n <= int'(LAT) + 6 && first == 0; n++) begin
            if (div_start) starts++;
            if (busy && !rsp_valid && (div_a !== a || div_b !== b)) stable = 1'b0;
            if (req0_ready || req1_ready) stable = 1'b0;
            if (rsp_valid) first = n;
            else @(negedge clk);
        end
        chk("latency", 64'(first), (b == '0) ? 64'd1 : 64'(LAT + 2));
        chk("div_start_pulses", 64'(starts), (b == '0) ? 64'd0 : 64'd1);
        chk("operand_stable", {63'd0, stable}, 64'd1);
        chk("rsp_id", {63'd0, rsp_id}, {63'd0, id});
        chk("rsp_q", 64'(rsp_q), 64'(eq));
        chk("rsp_err", {63'd0, rsp_err}, {63'd0, (b == '0)});
        if (stall > 0) begin
            hold = 1'b1;
            for (int s = 0; s < stall; s++) begin
                // The other requester knocks and leaves; it must be ignored.
                if (id) req0_valid = (s < stall - 2); else req1_valid = (s < stall - 2);
                @(negedge clk);
                if (!rsp_valid || rsp_q !== eq || rsp_id !== id) hold = 1'b0;
                if (req0_ready || req1_ready) hold = 1'b0;
            end
            chk("backpressure_hold", {63'd0, hold}, 64'd1);
            req0_valid = 1'b0; req1_valid = 1'b0;
            rsp_ready = 1'b1;
        end
        @(negedge clk);
        chk("single_handshake", {62'd0, rsp_valid, busy}, 64'd0);
        rsp_ready = 1'b0;
        exp_prio = ~id;
    endtask

    initial begin
        int last_acc, w;
        bit granted, quiet;
        logic [NI-1:0] ra, rb, ca0, cb0, ca1, cb1;

        rst_n = 1'b0; rsp_ready = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        div_q = '0; exp_prio = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", {54'd0, div_start, rsp_valid, rsp_err, rsp_id, busy,
                              req0_ready, req1_ready, 3'd0}, 64'd0);
        chk("reset_rsp_q", 64'(rsp_q), 64'd0);
        chk("reset_div_ab", {div_a, div_b}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic single request: 0.25 / 0.5 = 0.5.
        run_one(1'b0, 32'h4000_0000, 32'h8000_0000, 0);
        chk("basic_q_const", 64'(rsp_q), 64'h080_0000_0000);
        // Divide-by-zero from requester 1.
        run_one(1'b1, 32'h1234_5678, 32'h0, 0);

        // Contention: both valid, rsp_ready high, grants must alternate.
        ca0 = $urandom; cb0 = $urandom | 32'h8000_0000;
        ca1 = $urandom; cb1 = $urandom | 32'h4000_0000;
        req0_valid = 1'b1; req0_a = ca0; req0_b = cb0;
        req1_valid = 1'b1; req1_a = ca1; req1_b = cb1;
        rsp_ready = 1'b1;
        last_acc = 0;
        for (int g = 0; g < 4; g++) begin
            w = 0;
            #1;
            while (!(req0_ready || req1_ready) && w < int'(LAT) + 8) begin
                @(negedge clk); #1; w++;
            end
            granted = req1_ready;
            chk("cont_grant", {63'd0, granted}, {63'd0, exp_prio});
            chk("cont_grant_pattern", {63'd0, granted}, 64'(g % 2));
            if (g > 0) chk("cont_throughput", 64'(cyc - last_acc), 64'(LAT + 3));
            last_acc = cyc;
            @(negedge clk);
            w = 0;
            while (!rsp_valid && w < int'(LAT) + 8) begin @(negedge clk); w++; end
            chk("cont_rsp_id", {63'd0, rsp_id}, {63'd0, granted});
            chk("cont_rsp_q", 64'(rsp_q), 64'(granted ? ref_q(ca1, cb1) : ref_q(ca0, cb0)));
            exp_prio = ~granted;
            @(negedge clk);
        end
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
        @(negedge clk);

        // Backpressure for 10 cycles.
        run_one(1'b0, $urandom, $urandom | 32'h0100_0000, 10);

        // Randomized single requests.
        for (int i = 0; i < 8; i++) begin
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? '0 : NI'($urandom);
            run_one(1'($urandom_range(0, 1)), ra, rb, int'($urandom_range(0, 3)));
        end

        // Reset while the counter holds 20.
        req0_valid = 1'b1; req0_a = $urandom; req0_b = $urandom | 32'h1;
        @(negedge clk);
        req0_valid = 1'b0;
        repeat (int'(LAT) - 20 + 1) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midwait_reset_ctl", {59'd0, div_start, rsp_valid, rsp_err, rsp_id, busy}, 64'd0);
        chk("midwait_reset_q", 64'(rsp_q), 64'd0);
        chk("midwait_reset_ab", {div_a, div_b}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_prio = 1'b0;
        quiet = 1'b1;
        for (int n = 0; n < int'(LAT) + 6; n++) begin
            @(negedge clk);
            if (rsp_valid || busy || div_start) quiet = 1'b0;
        end
        chk("no_rsp_after_reset", {63'd0, quiet}, 64'd1);
        run_one(1'b1, $urandom, $urandom | 32'h0000_8000, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL timeout observed=running expected=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
